// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and counter sizing.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD         = 2'd0,
    ST_RUN          = 2'd1,
    ST_DEBOUNCE     = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } seq_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared to 0 by reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Shift the raw level through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: debounces the reset button, stretches reset by
// HOLD_CYCLES and produces a TICK_DIV clock-enable while the design runs.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int TICK_DIV        = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btn_i,
  output logic       rst_n_o,
  output logic       tick_o,
  output logic [1:0] state_o
);

  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int TW = cnt_width(TICK_DIV);

  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 32'sd1);
  // The cycle that first sees the button released already counts toward the hold.
  localparam logic [HW-1:0] HOLD_FIRST = (HOLD_CYCLES > 32'sd1) ? HW'(32'sd1) : '0;
  // Entering DEBOUNCE is the first high sample; the transition edge is the last.
  localparam logic [DW-1:0] DEB_LAST   = (DEBOUNCE_CYCLES > 32'sd2) ?
                                         DW'(DEBOUNCE_CYCLES - 32'sd2) : '0;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 32'sd1);
  localparam logic          TICK_EVERY = (TICK_DIV == 32'sd1);

  seq_state_e    state_r,    state_s;
  logic [HW-1:0] hold_cnt_r, hold_cnt_s;
  logic [DW-1:0] deb_cnt_r,  deb_cnt_s;
  logic [TW-1:0] tick_cnt_r, tick_cnt_s;
  logic          rst_n_r,    tick_r;
  logic          btn_s;
  logic          active_s,   was_active_s, tick_s;

  sync_2ff u_btn_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (btn_i),
    .q     (btn_s)
  );

  // Next-state and counter update for the sequencing FSM.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    deb_cnt_s  = deb_cnt_r;
    case (state_r)
      ST_HOLD: begin
        deb_cnt_s = '0;
        if (btn_s) begin
          hold_cnt_s = '0;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_s    = ST_RUN;
          hold_cnt_s = '0;
        end else begin
          hold_cnt_s = hold_cnt_r + 1'b1;
        end
      end
      ST_RUN: begin
        hold_cnt_s = '0;
        deb_cnt_s  = '0;
        if (btn_s) begin
          state_s = ST_DEBOUNCE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DEBOUNCE: begin
        hold_cnt_s = '0;
        if (!btn_s) begin
          state_s   = ST_RUN;
          deb_cnt_s = '0;
        end else if (deb_cnt_r == DEB_LAST) begin
          state_s   = ST_WAIT_RELEASE;
          deb_cnt_s = '0;
        end else begin
          deb_cnt_s = deb_cnt_r + 1'b1;
        end
      end
      ST_WAIT_RELEASE: begin
        deb_cnt_s = '0;
        if (!btn_s) begin
          state_s    = ST_HOLD;
          hold_cnt_s = HOLD_FIRST;
        end else begin
          hold_cnt_s = '0;
        end
      end
      default: begin
        state_s    = ST_HOLD;
        hold_cnt_s = '0;
        deb_cnt_s  = '0;
      end
    endcase
  end

  // Tick divider runs only while the design is out of reset.
  always_comb begin
    active_s     = (state_s == ST_RUN) || (state_s == ST_DEBOUNCE);
    was_active_s = (state_r == ST_RUN) || (state_r == ST_DEBOUNCE);
    tick_cnt_s   = '0;
    if (active_s && was_active_s && (tick_cnt_r != TICK_LAST)) begin
      tick_cnt_s = tick_cnt_r + 1'b1;
    end else begin
      tick_cnt_s = '0;
    end
    if (TICK_EVERY) begin
      tick_s = active_s;
    end else begin
      tick_s = active_s && was_active_s && (tick_cnt_r == TICK_LAST);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_HOLD;
      hold_cnt_r <= '0;
      deb_cnt_r  <= '0;
      tick_cnt_r <= '0;
      rst_n_r    <= 1'b0;
      tick_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      deb_cnt_r  <= deb_cnt_s;
      tick_cnt_r <= tick_cnt_s;
      rst_n_r    <= active_s;
      tick_r     <= tick_s;
    end
  end

  assign rst_n_o = rst_n_r;
  assign tick_o  = tick_r;
  assign state_o = state_r;

endmodule
